// File: rtl/cnt_seq_pkg.sv
// Shared types for the counter command sequencer: command opcodes, FSM states,
// the queued command record and the expected-count helper.
package cnt_seq_pkg;

  localparam int CMD_W = 4;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } cmd_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  typedef struct packed {
    cmd_op_t            op;
    logic [CMD_W-1:0]   arg;
  } cmd_t;

  // Count the counter should show once a command has finished, wrapping mod 2^CMD_W.
  function automatic logic [CMD_W-1:0] expected_count(input cmd_op_t op,
                                                       input logic [CMD_W-1:0] start,
                                                       input logic [CMD_W-1:0] arg);
    logic [CMD_W-1:0] val;
    val = start;
    case (op)
      OP_LOAD: val = arg;
      OP_UP:   val = start + arg;
      OP_DOWN: val = start - arg;
      default: val = start;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/cnt_cmd_fifo.sv
// Small synchronous FIFO of queued counter commands with a combinational head
// read; pointers carry one extra wrap bit to tell full from empty.
module cnt_cmd_fifo
  import cnt_seq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cnt_seq.sv
// Command-driven sequencer for an external up/down counter: queues commands,
// drives the counter controls for each one, then checks the returned count.
module cnt_seq
  import cnt_seq_pkg::*;
#(
  parameter int W     = CMD_W,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_arg,
  input  logic [W-1:0] cnt_q,
  output logic         cnt_en,
  output logic         cnt_up,
  output logic         cnt_load,
  output logic [W-1:0] cnt_din,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         err,
  input  logic         err_clr
);

  state_t       state;
  state_t       state_nx;
  cmd_t         fifo_in;
  cmd_t         head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         pop;
  cmd_op_t      op_r;
  logic [W-1:0] arg_r;
  logic [W-1:0] rem;
  logic [W-1:0] exp_r;

  assign fifo_in   = '{op: cmd_op_t'(cmd_op), arg: cmd_arg};
  assign push      = cmd_valid && !fifo_full;
  assign pop       = (state == S_IDLE) && !fifo_empty;
  assign cmd_ready = !fifo_full;
  assign busy      = (state != S_IDLE) || !fifo_empty;

  cnt_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Counter controls depend only on registered state so they never glitch.
  always_comb begin
    state_nx = state;
    cnt_en   = 1'b0;
    cnt_up   = 1'b0;
    cnt_load = 1'b0;
    cnt_din  = '0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (head.op == OP_LOAD)
            state_nx = S_LOAD;
          else if ((head.op == OP_UP || head.op == OP_DOWN) && head.arg != '0)
            state_nx = S_RUN;
          else
            state_nx = S_DONE;
        end
      end
      S_LOAD: begin
        cnt_load = 1'b1;
        cnt_din  = arg_r;
        state_nx = S_DONE;
      end
      S_RUN: begin
        cnt_en = 1'b1;
        cnt_up = (op_r == OP_UP);
        if (rem == W'(1)) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Command capture, run-length countdown, and the result/err checker.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_r   <= OP_NOP;
      arg_r  <= '0;
      rem    <= '0;
      exp_r  <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      if (pop) begin
        op_r  <= head.op;
        arg_r <= head.arg;
        rem   <= head.arg;
        exp_r <= expected_count(head.op, cnt_q, head.arg);
      end else if (state == S_RUN) begin
        rem <= rem - W'(1);
      end
      if (state == S_DONE) result <= cnt_q;
      if (state == S_DONE && cnt_q != exp_r) err <= 1'b1;
      else if (err_clr)                      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnt_seq.sv
// Self-checking bench for cnt_seq with a real 4-bit counter looped back,
// a queue-based scoreboard and an arithmetic reference model.
module tb_cnt_seq;

  localparam logic [1:0] C_NOP  = 2'd0;
  localparam logic [1:0] C_LOAD = 2'd1;
  localparam logic [1:0] C_UP   = 2'd2;
  localparam logic [1:0] C_DOWN = 2'd3;

  typedef struct {
    int res;
    int err;
    int en;
    int up;
    int load;
    int din;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_arg = 4'd0;
  logic [3:0] cnt_q;
  logic       cnt_en;
  logic       cnt_up;
  logic       cnt_load;
  logic [3:0] cnt_din;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       err;
  logic       err_clr = 1'b0;

  logic [3:0] count = 4'd0;
  logic       stuck = 1'b0;

  int   n_compared = 0;
  int   n_failed = 0;
  exp_t sb[$];
  int   model_count = 0;
  int   model_err = 0;

  int   en_cycles = 0;
  int   up_cycles = 0;
  int   load_cycles = 0;
  int   last_din = 0;
  bit   chk_pending = 1'b0;
  exp_t pend;

  always #5 clk = ~clk;

  assign cnt_q = stuck ? 4'd0 : count;

  always @(posedge clk) begin
    if (cnt_load)    count <= cnt_din;
    else if (cnt_en) count <= cnt_up ? count + 4'd1 : count - 4'd1;
  end

  cnt_seq dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .cnt_q     (cnt_q),
    .cnt_en    (cnt_en),
    .cnt_up    (cnt_up),
    .cnt_load  (cnt_load),
    .cnt_din   (cnt_din),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .err       (err),
    .err_clr   (err_clr)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    n_compared++;
    n_failed++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference model: each command's effect on the counter in plain modulo-16 arithmetic.
  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] arg);
    exp_t e;
    int   a;
    int   start;
    int   nxt;
    int   dut_exp;
    int   seen;
    int   guard;
    a = int'(arg);
    start = stuck ? 0 : model_count;
    e = '{res: 0, err: 0, en: 0, up: 0, load: 0, din: 0};
    case (op)
      C_LOAD: begin nxt = a; dut_exp = a; e.load = 1; e.din = a; end
      C_UP:   begin nxt = (model_count + a) % 16; dut_exp = (start + a) % 16; e.en = a; e.up = a; end
      C_DOWN: begin nxt = (model_count + 16 - a) % 16; dut_exp = (start + 16 - a) % 16; e.en = a; end
      default: begin nxt = model_count; dut_exp = start; end
    endcase
    seen = stuck ? 0 : nxt;
    if (seen != dut_exp) model_err = 1;
    e.res = seen;
    e.err = model_err;
    model_count = nxt;
    sb.push_back(e);

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    guard = 0;
    while (!cmd_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      timeoutFail("cmd_accept");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0 || chk_pending) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (busy || sb.size() != 0 || chk_pending) timeoutFail("wait_idle");
  endtask

  task automatic waitDone(output int lat);
    lat = -1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i - 1;
        break;
      end
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_cnt_en"},    int'(cnt_en),    0);
    checkOutput({tag, "_cnt_up"},    int'(cnt_up),    0);
    checkOutput({tag, "_cnt_load"},  int'(cnt_load),  0);
    checkOutput({tag, "_cnt_din"},   int'(cnt_din),   0);
    checkOutput({tag, "_done"},      int'(done),      0);
    checkOutput({tag, "_busy"},      int'(busy),      0);
    checkOutput({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    checkOutput({tag, "_result"},    int'(result),    0);
    checkOutput({tag, "_err"},       int'(err),       0);
  endtask

  // Monitor: tallies counter activity per command and scores each done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      en_cycles   = 0;
      up_cycles   = 0;
      load_cycles = 0;
      chk_pending = 1'b0;
    end else begin
      if (chk_pending) begin
        checkOutput("result", int'(result), pend.res);
        checkOutput("err", int'(err), pend.err);
        chk_pending = 1'b0;
      end
      if (cnt_en) begin
        en_cycles++;
        if (cnt_up) up_cycles++;
      end
      if (cnt_load) begin
        load_cycles++;
        last_din = int'(cnt_din);
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_compared++;
          n_failed++;
          $display("[TB] FAIL unexpected_done: got done=1, want no pending command");
        end else begin
          pend = sb.pop_front();
          checkOutput("en_cycles", en_cycles, pend.en);
          checkOutput("up_cycles", up_cycles, pend.up);
          checkOutput("load_cycles", load_cycles, pend.load);
          if (pend.load != 0) checkOutput("load_din", last_din, pend.din);
          chk_pending = 1'b1;
        end
        en_cycles   = 0;
        up_cycles   = 0;
        load_cycles = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int guard;
    int hold;
    logic [1:0] rop;
    logic [3:0] rarg;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("init");
    rst = 1'b1;

    // Abort a long UP with a 4-cycle reset.
    applyStimulus(C_LOAD, 4'd7);
    waitIdle();
    applyStimulus(C_UP, 4'd10);
    guard = 0;
    while (!cnt_en && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!cnt_en) timeoutFail("wait_run");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    sb.delete();
    model_err = 0;
    rst = 1'b1;
    checkReset("abort");
    hold = int'(count);
    repeat (3) @(negedge clk);
    checkOutput("cnt_hold_after_reset", int'(count), hold);

    // Single LOAD and its latency.
    applyStimulus(C_LOAD, 4'd3);
    waitDone(lat);
    checkOutput("load_latency", lat, 2);
    waitIdle();

    // Back-to-back LOAD 14, UP 5 wrapping through 15.
    applyStimulus(C_LOAD, 4'd14);
    applyStimulus(C_UP, 4'd5);
    waitIdle();
    checkOutput("wrap_up_result", int'(result), 3);

    // DOWN 4 from 3 wraps to 15, then zero-length commands.
    applyStimulus(C_DOWN, 4'd4);
    waitDone(lat);
    checkOutput("down4_latency", lat, 5);
    waitIdle();
    applyStimulus(C_UP, 4'd0);
    waitDone(lat);
    checkOutput("up0_latency", lat, 1);
    waitIdle();
    applyStimulus(C_NOP, 4'd9);
    waitDone(lat);
    checkOutput("nop_latency", lat, 1);
    waitIdle();

    // Fill the FIFO while a RUN of 8 is in progress.
    applyStimulus(C_UP, 4'd8);
    applyStimulus(C_LOAD, 4'd9);
    applyStimulus(C_UP, 4'd2);
    @(negedge clk);
    checkOutput("ready_when_full", int'(cmd_ready), 0);
    checkOutput("busy_when_full", int'(busy), 1);
    applyStimulus(C_DOWN, 4'd5);
    waitIdle();
    checkOutput("ordered_result", int'(result), 6);

    // Stuck count feedback raises a sticky err.
    stuck = 1'b1;
    applyStimulus(C_UP, 4'd2);
    waitIdle();
    stuck = 1'b0;
    applyStimulus(C_LOAD, 4'd0);
    waitIdle();
    checkOutput("err_sticky", int'(err), 1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    model_err = 0;
    checkOutput("err_cleared", int'(err), 0);

    // Randomized command stream with random gaps.
    for (int i = 0; i < 24; i++) begin
      rop  = 2'($urandom_range(0, 3));
      rarg = 4'($urandom_range(0, 15));
      applyStimulus(rop, rarg);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    waitIdle();
    checkOutput("final_count", int'(count), model_count);
    checkOutput("final_err", int'(err), model_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/cnt_seq.md
Name: cnt_seq

Overview:
Command-driven sequencer for the team's 4-bit up/down counter with load, enable and reset. It accepts LOAD/UP/DOWN commands over a valid/ready interface and buffers them in a 2-entry FIFO. It drives the counter's en/up/load/count_in controls for the exact number of cycles each command needs, then checks the returned count against an expected value. It sits between a host/test controller and the counter instance. The counter stays external.

Parameters:
W, 4, counter data width (cmd_arg, cnt_din, cnt_q, result)
DEPTH, 2, command FIFO depth (power of 2, ≥2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; high when not full
cmd_op  in  2  00 NOP, 01 LOAD, 10 UP, 11 DOWN
cmd_arg  in  W  LOAD: value; UP/DOWN: step count; NOP: ignored
cnt_q  in  W  current count fed back from counter
cnt_en  out  1  counter enable
cnt_up  out  1  counter direction, 1=up
cnt_load  out  1  counter load strobe
cnt_din  out  W  counter load value
busy  out  1  state≠IDLE or FIFO non-empty
done  out  1  one-cycle pulse at command completion
result  out  W  cnt_q sampled in DONE, held until next DONE
err  out  1  sticky: result≠expected at some DONE
err_clr  in  1  clears err (lower priority than a new mismatch in same cycle)

Behaviour:
- Reset (rst==0 at clk edge): state=IDLE, FIFO flushed, result=0, err=0. cnt_en/cnt_up/cnt_load/done=0, cnt_din=0, cmd_ready=1, busy=0. Reset mid-command aborts it with no done pulse.
- Handshake: push on cmd_valid&&cmd_ready. cmd_ready is registered-state based: low while FIFO holds DEPTH entries, no push-when-full. Commands execute strictly in order.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: if FIFO non-empty, pop the head and capture start=cnt_q, op, arg (remaining=arg).
  - LOAD → LOAD, exp=arg.
  - UP/DOWN with arg≠0 → RUN, exp=start±arg mod 2^W.
  - NOP or arg==0 → DONE, exp=start.
- LOAD (1 cycle): cnt_load=1, cnt_din=arg, cnt_en=0 → DONE.
- RUN: cnt_en=1, cnt_up=(op==UP), remaining decrements each cycle. Exactly arg cycles; at remaining==1 → DONE.
- DONE (1 cycle): done=1, result<=cnt_q. If cnt_q≠exp, err<=1. Then → IDLE.
- Outputs are decoded from registered state, so cnt_* are glitch-free relative to clk. All cnt_* are 0 in IDLE and DONE.
- Timing: command accepted at edge k → popped at edge k+1 → controls active from cycle k+1. UP/DOWN N completes with done high in the cycle after edge k+N+1. LOAD has done 2 cycles after pop. Minimum spacing is 2 overhead cycles per command (DONE, IDLE).
- Wrap: UP past 2^W-1 → 0; DOWN past 0 → 2^W-1; exp uses the same modulo arithmetic.
- A push in the same cycle as a pop is allowed when the FIFO is not full.
- err_clr with no mismatch that cycle: err<=0.

Decomposition:
- Package cnt_seq_pkg:
  - typedef enum logic[1:0] cmd_op_t {OP_NOP, OP_LOAD, OP_UP, OP_DOWN}
  - typedef enum state_t {S_IDLE, S_LOAD, S_RUN, S_DONE}
  - struct cmd_t {op, arg}
- Sub-module cnt_cmd_fifo: synchronous FIFO of cmd_t with push/pop, full/empty, same active-low sync reset.
- FSM, expected-value datapath and checker live in cnt_seq.

Test Plan:
- Bench instantiates cnt_seq with a real counter, cnt_q looped back.
1. rst=0 for 4 cycles during a RUN of UP 10 → next cycle all cnt_*=0, done=0, busy=0, cmd_ready=1, result=0, err=0. Counter not advanced further.
2. LOAD 3 → cnt_load high exactly 1 cycle with cnt_din=3. done pulse 2 cycles after pop, result=3, err=0.
3. LOAD 14 then UP 5 issued back-to-back → cnt_en high 5 consecutive cycles with cnt_up=1. Count goes 15,0,1,2,3; result=3, err=0.
4. From 3, DOWN 4 → count goes 2,1,0,15; result=15. Then UP 0 and NOP → each gives done with no cnt_en, result=15.
5. Hold cmd_valid with 3 commands while a RUN of 8 is executing → cmd_ready drops after 2 accepted. Third is accepted after the next pop; execution order matches issue order.
6. Bench forces cnt_q stuck at 0, issue UP 2 → err=1 after done. err stays 1 through a following good LOAD 0; err_clr pulse → err=0.
